// File: rtl/ff_sync_bank.sv
// Multi-channel synchroniser into the clk_b domain with clean level and rise/fall pulses.
// Define FF_SYNC_FILTER_EN to compile in the per-channel stability filter.
module ff_sync_bank #(
  parameter int unsigned      WIDTH      = 4,
  parameter int unsigned      STAGES     = 2,
  parameter int unsigned      FILTER_CNT = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk_b,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] sig_a,
  output logic [WIDTH-1:0] sig_b,
  output logic [WIDTH-1:0] rise_b,
  output logic [WIDTH-1:0] fall_b
);

  // Elaboration-time parameter sanity
  if (WIDTH < 1 || STAGES < 2 || FILTER_CNT < 1) begin : g_bad_param
    $error("ff_sync_bank: WIDTH>=1, STAGES>=2, FILTER_CNT>=1 required");
  end

  logic [STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0]             s;
  logic [WIDTH-1:0]             next_sig_b;

  // Pure flop chain, nothing between stages
  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      sync <= {STAGES{RESET_VAL}};
    end else begin
      sync[0] <= sig_a;
      for (int unsigned n = 1; n < STAGES; n++) begin
        sync[n] <= sync[n-1];
      end
    end
  end

  assign s = sync[STAGES-1];

`ifdef FF_SYNC_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);

  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;

  // Any cycle where s agrees with sig_b discards the pending count
  always_comb begin
    next_sig_b = sig_b;
    cnt_nxt    = cnt;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s[i] == sig_b[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        next_sig_b[i] = s[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`else
  always_comb begin
    next_sig_b = s;
  end
`endif

  // Level and edge pulses update on the same edge
  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      sig_b  <= RESET_VAL;
      rise_b <= '0;
      fall_b <= '0;
    end else begin
      sig_b  <= next_sig_b;
      rise_b <= ~sig_b & next_sig_b;
      fall_b <= sig_b & ~next_sig_b;
    end
  end

endmodule

// File: tb/tb_ff_sync_bank.sv
// Self-checking bench for ff_sync_bank: directed scenarios plus randomized traffic
// checked every cycle against a sample-history reference model.
module tb_ff_sync_bank;

  localparam int unsigned W  = 4;
  localparam int unsigned ST = 2;
  localparam int unsigned FC = 4;
`ifdef FF_SYNC_FILTER_EN
  localparam int unsigned EFC = FC;
`else
  localparam int unsigned EFC = 1;
`endif
  localparam int unsigned LAT = ST + EFC - 1;

  logic         clk_b = 1'b0;
  logic         rst_b = 1'b1;
  logic [W-1:0] sig_a = '0;
  logic [W-1:0] sig_b;
  logic [W-1:0] rise_b;
  logic [W-1:0] fall_b;

  int checks = 0;
  int errors = 0;

  // Reference: history of input samples per edge, newest first
  logic [W-1:0] hist[$];
  logic [W-1:0] m_sig  = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;

  always #5 clk_b = ~clk_b;

  ff_sync_bank #(
    .WIDTH(W), .STAGES(ST), .FILTER_CNT(FC), .RESET_VAL('0)
  ) dut (
    .clk_b (clk_b),
    .rst_b (rst_b),
    .sig_a (sig_a),
    .sig_b (sig_b),
    .rise_b(rise_b),
    .fall_b(fall_b)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A channel's level flips once the EFC samples that have reached the filter all disagree with it
  task automatic model_edge();
    logic [W-1:0] nxt;
    logic [W-1:0] h;
    int ones;
    if (rst_b) begin
      hist.delete();
      for (int j = 0; j < int'(ST + EFC); j++) hist.push_back('0);
      m_sig  = '0;
      m_rise = '0;
      m_fall = '0;
    end else begin
      hist.push_front(sig_a);
      void'(hist.pop_back());
      nxt = m_sig;
      for (int i = 0; i < int'(W); i++) begin
        ones = 0;
        for (int j = int'(ST); j < int'(ST + EFC); j++) begin
          h = hist[j];
          ones += int'(h[i]);
        end
        if (ones == int'(EFC)) nxt[i] = 1'b1;
        else if (ones == 0)    nxt[i] = 1'b0;
      end
      m_rise = ~m_sig & nxt;
      m_fall = m_sig & ~nxt;
      m_sig  = nxt;
    end
  endtask

  task automatic step();
    @(posedge clk_b);
    model_edge();
    #1;
    check("sig_b", sig_b, m_sig);
    check("rise_b", rise_b, m_rise);
    check("fall_b", fall_b, m_fall);
  endtask

  task automatic settle(input logic [W-1:0] v);
    sig_a = v;
    for (int j = 0; j < int'(LAT) + 3; j++) step();
  endtask

  initial begin
    int rises;
    int hold;
    for (int j = 0; j < int'(ST + EFC); j++) hist.push_back('0);

    // Reset with inputs high, then release and time the first rise
    sig_a = 4'hF;
    rst_b = 1'b1;
    for (int j = 0; j < 3; j++) step();
    check("reset_sig_b", sig_b, 4'h0);
    check("reset_rise_b", rise_b, 4'h0);
    check("reset_fall_b", fall_b, 4'h0);
    rst_b = 1'b0;
    for (int j = 1; j <= int'(LAT) + 2; j++) begin
      step();
      check("release_rise", rise_b, (j == int'(LAT) + 1) ? 4'hF : 4'h0);
    end
    check("release_level", sig_b, 4'hF);

    // Glitch rejection on channel 0
    settle(4'h0);
    rises = 0;
    sig_a = 4'h1;
    for (int j = 0; j < 3; j++) begin step(); rises += int'(rise_b[0]); end
    sig_a = 4'h0;
    for (int j = 0; j < int'(LAT) + 3; j++) begin step(); rises += int'(rise_b[0]); end
`ifdef FF_SYNC_FILTER_EN
    check("glitch_rises", W'(rises), W'(0));
`endif
    rises = 0;
    sig_a = 4'h1;
    for (int j = 0; j < 6; j++) begin step(); rises += int'(rise_b[0]); end
    for (int j = 0; j < int'(LAT) + 3; j++) begin step(); rises += int'(rise_b[0]); end
    check("long_pulse_rises", W'(rises), W'(1));
    check("long_pulse_level", sig_b, 4'h1);

    // Latency on channel 1, both directions
    settle(4'h0);
    sig_a = 4'h2;
    for (int j = 1; j <= int'(LAT) + 2; j++) begin
      step();
      check("lat_rise", rise_b, (j == int'(LAT) + 1) ? 4'h2 : 4'h0);
    end
    settle(4'h2);
    sig_a = 4'h0;
    for (int j = 1; j <= int'(LAT) + 2; j++) begin
      step();
      check("lat_fall", fall_b, (j == int'(LAT) + 1) ? 4'h2 : 4'h0);
    end

    // Simultaneous opposite changes on channels 2 and 3
    settle(4'h8);
    sig_a = 4'h4;
    for (int j = 1; j <= int'(LAT) + 1; j++) step();
    check("simul_rise", rise_b, 4'h4);
    check("simul_fall", fall_b, 4'h8);
    check("simul_level", sig_b, 4'h4);

    // Reset in the middle of a pending change
    settle(4'h0);
    sig_a = 4'h1;
    for (int j = 0; j < 3; j++) step();
`ifdef FF_SYNC_FILTER_EN
    check("midfilt_pending", sig_b, 4'h0);
`endif
    rst_b = 1'b1;
    step();
    check("midfilt_reset", sig_b, 4'h0);
    rst_b = 1'b0;
    for (int j = 1; j <= int'(LAT) + 2; j++) begin
      step();
      check("midfilt_rise", rise_b, (j == int'(LAT) + 1) ? 4'h1 : 4'h0);
    end

    // Randomized hold lengths, occasional resets
    for (int n = 0; n < 400; n++) begin
      sig_a = W'($urandom);
      rst_b = ($urandom_range(0, 39) == 0);
      hold  = $urandom_range(1, 8);
      for (int j = 0; j < hold; j++) begin
        step();
        rst_b = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_sync_bank.md
# ff_sync_bank

Parametrised multi-channel input synchroniser for the destination clock domain. Each of WIDTH asynchronous inputs passes through a STAGES-deep flip-flop chain clocked by `clk_b`, then an optional per-channel stability filter, and produces a clean level plus one-cycle rise and fall pulses. It sits at every asynchronous boundary where single-bit control or status signals enter the `clk_b` domain, and replaces hand-instantiated two-flop synchronisers.

## Interface

- WIDTH, 4, number of independent single-bit channels (≥1)
- STAGES, 2, synchroniser depth per channel (≥2)
- FILTER_CNT, 4, consecutive cycles a synchronised value must differ from `sig_b` before `sig_b` updates (≥1)
- RESET_VAL, {WIDTH{1'b0}}, reset value loaded into every sync stage and into `sig_b`

- clk_b  input  1  destination clock; all logic on its rising edge
- rst_b  input  1  synchronous, active-high reset
- sig_a  input  WIDTH  asynchronous inputs, no timing relation to `clk_b`
- sig_b  output  WIDTH  synchronised, filtered levels
- rise_b  output  WIDTH  one-cycle pulse per channel when `sig_b[i]` goes 0→1
- fall_b  output  WIDTH  one-cycle pulse per channel when `sig_b[i]` goes 1→0

One clock; reset is synchronous and active-high.

## Operation

- Per channel i: chain `sync[i][0..STAGES-1]`; `sync[i][0] <= sig_a[i]`, `sync[i][n] <= sync[i][n-1]`; `s[i] = sync[i][STAGES-1]`. No logic between chain flops.
- Filter per channel: counter `cnt[i]`, width $clog2(FILTER_CNT+1).
  - `s[i] == sig_b[i]`: `cnt[i] <= 0`.
  - `s[i] != sig_b[i]` and `cnt[i] < FILTER_CNT-1`: `cnt[i] <= cnt[i]+1`.
  - `s[i] != sig_b[i]` and `cnt[i] == FILTER_CNT-1`: `sig_b[i] <= s[i]`, `cnt[i] <= 0`.
- A return of `s[i]` to `sig_b[i]` on any cycle discards the pending count; glitches shorter than FILTER_CNT cycles at `s` never reach `sig_b`.
- Edge pulses registered and updated on the same edge as `sig_b`: `rise_b[i] <= ~sig_b[i] & next_sig_b[i]`, `fall_b[i] <= sig_b[i] & ~next_sig_b[i]`. Pulse is high in exactly the cycle `sig_b[i]` first shows its new value, for one cycle.
- Channels fully independent; simultaneous changes on several channels produce simultaneous pulses.
- Reset (`rst_b`=1 at an edge): all sync stages and `sig_b` ← RESET_VAL, all `cnt` ← 0, `rise_b`/`fall_b` ← 0. Reset asserted mid-filter aborts pending changes. Reset never generates a pulse; the first cycle after release cannot pulse unless a filter completed on that edge.

## Timing

- Reset values: `sig_b`=RESET_VAL, `rise_b`=0, `fall_b`=0.
- `sig_a[i]` stable before edge k: `sync[i][0]` updates at edge k, `s[i]` at edge k+STAGES-1, `sig_b[i]` and pulse at edge k+STAGES+FILTER_CNT-1.
- Defaults (STAGES=2, FILTER_CNT=4): latency 5 `clk_b` edges.
- Minimum detectable input high/low time: FILTER_CNT+1 `clk_b` periods (one extra period covers sampling uncertainty).
- Maximum toggle rate at `sig_b`: one change per FILTER_CNT cycles per channel.

## Configuration

- `FF_SYNC_FILTER_EN` defined: stability filter and counters compiled in as described.
- Not defined: counters removed, FILTER_CNT ignored; `sig_b <= s` every cycle (behaves as FILTER_CNT=1). Latency STAGES edges; pulses still generated; any pulse that survives the chain propagates.

## Test plan

Defaults unless stated; `clk_b` period 10.
- Reset: `sig_a`=4'hF, `rst_b`=1 for 3 edges → `sig_b`=4'h0, no pulses; release, `sig_a` held → `sig_b`=4'hF and `rise_b`=4'hF for one cycle exactly 5 edges after release.
- Glitch reject: `sig_a[0]` high for 3 `clk_b` cycles → `sig_b[0]` stays 0, `rise_b[0]` never 1; high for 6 cycles → `sig_b[0]`=1 with one `rise_b[0]` pulse.
- Latency: `sig_a[1]` 0→1 before edge k → `sig_b[1]`=1 and `rise_b[1]`=1 at edge k+5; `rise_b[1]`=0 at k+6; later 1→0 → one `fall_b[1]` pulse 5 edges after.
- Simultaneous: `sig_a[2]` 0→1 and `sig_a[3]` 1→0 (from settled 4'h8) in the same cycle → `rise_b`=4'h4 and `fall_b`=4'h8 in the same cycle.
- Reset mid-filter: `sig_a[0]` rises, `rst_b` pulsed at edge k+3 → no change/pulse; after release, `sig_b[0]` rises 5 edges later.
- Macro off, STAGES=3: 2-cycle high on `sig_a[0]` → `sig_b[0]` high for 2 cycles starting edge k+3, one `rise_b` and one `fall_b` pulse.
